// File: rtl/clock_enable_bank.sv
// clock_enable_bank: runtime-programmable bank of integer/fractional clock-enable strobes gated by a synchronised lock
module clock_enable_bank #(
    parameter int CHANNELS = 8,
    parameter int ACC_W    = 24,
    parameter int CHAN_W   = 4
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                locked,
    input  logic                sync_all,
    input  logic                wr_en,
    input  logic [CHAN_W-1:0]   wr_chan,
    input  logic                wr_mode,
    input  logic [ACC_W-1:0]    wr_data,
    output logic [CHANNELS-1:0] ce,
    output logic [CHANNELS-1:0] tgl,
    output logic                ready
);
    logic sync1_q, sync1_d, ready_q, ready_d, run;
    always_comb begin
        sync1_d = locked;
        ready_d = sync1_q;
        run     = ready_q && sync1_q;
    end
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            ready_q <= ready_d;
        end
    end
    assign ready = ready_q;
    genvar i;
    for (i = 0; i < CHANNELS; i++) begin : g_ch
        logic [ACC_W-1:0] inc_q, inc_d, acc_q, acc_d;
        logic [ACC_W:0]   sum;
        logic             mode_q, mode_d, ce_q, ce_d, tgl_q, tgl_d, wr, clr;
        // acc_q doubles as the down-counter in integer mode; a clear reloads it for the mode being entered
        always_comb begin
            wr     = wr_en && (wr_chan == CHAN_W'(i));
            clr    = !run || sync_all || wr;
            inc_d  = wr ? wr_data : inc_q;
            mode_d = wr ? wr_mode : mode_q;
            sum    = {1'b0, acc_q} + {1'b0, inc_q};
            acc_d  = clr ? (mode_d ? inc_d : '0) :
                     mode_q ? ((acc_q == '0) ? inc_q : acc_q - ACC_W'(1)) : sum[ACC_W-1:0];
            ce_d   = !clr && (mode_q ? (acc_q == '0) : sum[ACC_W]);
            tgl_d  = tgl_q ^ ce_d;
        end
        always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
                inc_q  <= '0;
                mode_q <= 1'b0;
                acc_q  <= '0;
                ce_q   <= 1'b0;
                tgl_q  <= 1'b0;
            end else begin
                inc_q  <= inc_d;
                mode_q <= mode_d;
                acc_q  <= acc_d;
                ce_q   <= ce_d;
                tgl_q  <= tgl_d;
            end
        end
        assign ce[i]  = ce_q;
        assign tgl[i] = tgl_q;
    end
endmodule

// File: tb/tb_clock_enable_bank.sv
// tb_clock_enable_bank: directed scenario tests for clock_enable_bank with hand-computed strobe timing
module tb_clock_enable_bank;
    localparam int CHANNELS = 8;
    localparam int ACC_W    = 24;
    localparam int CHAN_W   = 4;

    logic                refclk = 1'b0;
    logic                rst = 1'b1;
    logic                locked = 1'b0;
    logic                sync_all = 1'b0;
    logic                wr_en = 1'b0;
    logic [CHAN_W-1:0]   wr_chan = '0;
    logic                wr_mode = 1'b0;
    logic [ACC_W-1:0]    wr_data = '0;
    logic [CHANNELS-1:0] ce, tgl;
    logic                ready;
    int checks = 0;
    int errors = 0;

    clock_enable_bank #(.CHANNELS(CHANNELS), .ACC_W(ACC_W), .CHAN_W(CHAN_W)) dut (
        .refclk(refclk), .rst(rst), .locked(locked), .sync_all(sync_all),
        .wr_en(wr_en), .wr_chan(wr_chan), .wr_mode(wr_mode), .wr_data(wr_data),
        .ce(ce), .tgl(tgl), .ready(ready)
    );

    always #5 refclk = ~refclk;

    // advance one rising edge, then settle 1 time unit so inputs/outputs are away from the edge
    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic write(input logic [CHAN_W-1:0] ch, input logic mode, input logic [ACC_W-1:0] data);
        wr_en = 1'b1; wr_chan = ch; wr_mode = mode; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (ce !== '0) begin errors++; $display("FAIL reset_ce got %h want 00", ce); end
        checks++; if (tgl !== '0) begin errors++; $display("FAIL reset_tgl got %h want 00", tgl); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        rst = 1'b0;
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL unlocked_ready got %b want 0", ready); end
    endtask

    task automatic test_lock_rise();
        locked = 1'b1;
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL lock_edge1_ready got %b want 0", ready); end
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL lock_edge2_ready got %b want 1", ready); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (ce !== '0) begin errors++; $display("FAIL idle_ce k=%0d got %h want 00", k, ce); end
        end
    endtask

    task automatic test_int_div();
        write(4'd0, 1'b1, 24'd3);
        checks++; if (ce[0] !== 1'b0) begin errors++; $display("FAIL div_write_edge_ce got %b want 0", ce[0]); end
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (ce[0] !== (k % 4 == 0) || tgl[0] !== ((k / 4) % 2 == 1)) begin
                errors++;
                $display("FAIL div3 k=%0d got ce=%b tgl=%b want ce=%b tgl=%b", k, ce[0], tgl[0], k % 4 == 0, (k / 4) % 2 == 1);
            end
        end
    endtask

    task automatic test_frac();
        int cnt;
        longint want;
        write(4'd1, 1'b0, 24'h400000);
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (ce[1] !== (k % 4 == 0)) begin errors++; $display("FAIL frac_quarter k=%0d got %b want %b", k, ce[1], k % 4 == 0); end
        end
        write(4'd1, 1'b0, 24'h4E4E4E);
        cnt = 0;
        for (int k = 0; k < 20000; k++) begin
            tick();
            cnt += int'(ce[1]);
        end
        want = (longint'(20000) * longint'(24'h4E4E4E)) >> 24;
        checks++;
        if (longint'(cnt) > want + 1 || longint'(cnt) + 1 < want) begin
            errors++; $display("FAIL frac_rate got %0d strobes want %0d +-1", cnt, want);
        end
    endtask

    task automatic test_sync_all();
        write(4'd1, 1'b0, 24'h400000);
        tick();
        tick();
        sync_all = 1'b1;
        tick();
        sync_all = 1'b0;
        checks++; if (ce[1:0] !== 2'b00) begin errors++; $display("FAIL sync_edge_ce got %b want 00", ce[1:0]); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (ce[1:0] !== ((k == 4) ? 2'b11 : 2'b00)) begin
                errors++; $display("FAIL sync_align k=%0d got %b want %b", k, ce[1:0], (k == 4) ? 2'b11 : 2'b00);
            end
        end
    endtask

    task automatic test_lock_drop();
        logic [CHANNELS-1:0] tgl_hold;
        tick();
        tick();
        locked = 1'b0;
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL drop_edge1_ready got %b want 1", ready); end
        tick();
        checks++;
        if (ready !== 1'b0 || ce !== '0) begin errors++; $display("FAIL drop_edge2 got ready=%b ce=%h want ready=0 ce=00", ready, ce); end
        tgl_hold = tgl;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (ce !== '0 || tgl !== tgl_hold) begin
                errors++; $display("FAIL unlocked_hold k=%0d got ce=%h tgl=%h want ce=00 tgl=%h", k, ce, tgl, tgl_hold);
            end
        end
        locked = 1'b1;
        tick();
        tick();
        checks++;
        if (ready !== 1'b1 || ce !== '0) begin errors++; $display("FAIL relock got ready=%b ce=%h want ready=1 ce=00", ready, ce); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (ce[1:0] !== ((k == 4) ? 2'b11 : 2'b00)) begin
                errors++; $display("FAIL relock_restart k=%0d got %b want %b", k, ce[1:0], (k == 4) ? 2'b11 : 2'b00);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [CHANNELS-1:0] want;
        wr_en = 1'b1; wr_chan = 4'd2; wr_mode = 1'b1; wr_data = 24'd1; sync_all = 1'b1;
        tick();
        sync_all = 1'b0;
        wr_chan = 4'd12; wr_data = 24'd0;
        checks++; if (ce !== '0) begin errors++; $display("FAIL wr_sync_edge_ce got %h want 00", ce); end
        for (int k = 1; k <= 8; k++) begin
            tick();
            wr_en = 1'b0;
            want = ((k % 2 == 0) ? 8'h04 : 8'h00) | ((k % 4 == 0) ? 8'h03 : 8'h00);
            checks++;
            if (ce !== want) begin errors++; $display("FAIL wr_sync_run k=%0d got %h want %h", k, ce, want); end
        end
    endtask

    initial begin
        test_reset();
        test_lock_rise();
        test_int_div();
        test_frac();
        test_sync_all();
        test_lock_drop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
